// File: rtl/rsort_seq_if.sv
// Stream bundle for rsort_seq: word input and sorted output channels.
// master = producer/consumer side, slave = sorter side.
interface rsort_seq_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/rsort_seq.sv
// Sequential N-word descending sorter: odd-even transposition, one exchange per cycle.
// Optional macro RSORT_SEQ_EARLY_EXIT_EN ends SORT once a pass pair makes no swap.
module rsort_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 8
) (
    input  logic       clk,
    input  logic       rst,
    rsort_seq_if.slave bus,
    output logic       busy
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam int PW = $clog2(N + 2);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SORT,
        ST_OUT
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         r_ptr;
    logic [PW-1:0]         r_pass;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_mem [N];

    logic [CW-1:0]         w_ptr1;
    logic [DATA_WIDTH-1:0] w_a;
    logic [DATA_WIDTH-1:0] w_b;
    logic                  w_swap;
    logic                  w_pass_end;
    logic                  w_done;
    logic                  w_last;
    int                    w_np;
    int                    w_ni;
    int                    w_ie;
`ifdef RSORT_SEQ_EARLY_EXIT_EN
    logic                  r_flag;
    logic                  w_flag;
`endif

    // Current pair compare and next-pair / next-pass sequencing
    always_comb begin
        w_ptr1     = r_ptr + CW'(1);
        w_a        = r_mem[r_ptr];
        w_b        = r_mem[w_ptr1];
        w_swap     = (w_a < w_b);
        w_ie       = int'(r_ptr) + 2;
        w_pass_end = (w_ie + 1 >= N);
        w_np       = int'(r_pass) + 1;
        w_ni       = w_np % 2;
        // odd passes have no pairs when N=2; skip straight past them
        if (w_ni + 1 >= N) begin
            w_np = w_np + 1;
            w_ni = w_np % 2;
        end
`ifdef RSORT_SEQ_EARLY_EXIT_EN
        w_flag = r_flag | w_swap;
        w_done = w_pass_end &&
                 ((w_np >= N) || ((w_ni == 0) && !w_flag));
`else
        w_done = w_pass_end && (w_np >= N);
`endif
        w_last = (r_cnt == CW'(N - 1));
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_valid ? r_mem[r_cnt] : '0;
    assign bus.out_last  = r_out_valid && w_last;
    assign busy          = r_busy;

    // Control FSM with storage: load, in-place sort, drain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_LOAD;
            r_cnt       <= '0;
            r_ptr       <= '0;
            r_pass      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef RSORT_SEQ_EARLY_EXIT_EN
            r_flag      <= 1'b0;
`endif
            for (int k = 0; k < N; k++) begin
                r_mem[k] <= '0;
            end
        end else begin
            unique case (r_state)
                ST_LOAD: begin
                    if (bus.in_valid) begin
                        r_mem[r_cnt] <= bus.in_data;
                        if (w_last) begin
                            r_state    <= ST_SORT;
                            r_cnt      <= '0;
                            r_ptr      <= '0;
                            r_pass     <= '0;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b1;
`ifdef RSORT_SEQ_EARLY_EXIT_EN
                            r_flag     <= 1'b0;
`endif
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                ST_SORT: begin
                    if (w_swap) begin
                        r_mem[r_ptr]  <= w_b;
                        r_mem[w_ptr1] <= w_a;
                    end
                    if (w_pass_end) begin
                        if (w_done) begin
                            r_state     <= ST_OUT;
                            r_cnt       <= '0;
                            r_busy      <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_pass <= PW'(w_np);
                            r_ptr  <= CW'(w_ni);
`ifdef RSORT_SEQ_EARLY_EXIT_EN
                            r_flag <= (w_ni == 0) ? 1'b0 : w_flag;
`endif
                        end
                    end else begin
                        r_ptr <= CW'(w_ie);
`ifdef RSORT_SEQ_EARLY_EXIT_EN
                        r_flag <= w_flag;
`endif
                    end
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        if (w_last) begin
                            r_state     <= ST_LOAD;
                            r_cnt       <= '0;
                            r_out_valid <= 1'b0;
                            r_in_ready  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end
endmodule
